// File: rtl/ram_sync_2r1w_if.sv
// Bundle of the load, fetch and write channels between the RV32I core and ram_sync_2r1w.
// The master is the core side; the slave is the RAM.
interface ram_sync_2r1w_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int LANES = DATA_WIDTH / 8;

  logic                  i_rd_req;
  logic [ADDR_WIDTH-1:0] i_rd_addr;
  logic                  o_rd_valid;
  logic                  i_rd_ready;
  logic [DATA_WIDTH-1:0] o_rd_data;
  logic                  o_rd_err;

  logic                  i_if_req;
  logic [ADDR_WIDTH-1:0] i_if_addr;
  logic                  o_if_valid;
  logic                  i_if_ready;
  logic [DATA_WIDTH-1:0] o_if_data;
  logic                  o_if_err;

  logic                  i_wr_en;
  logic [LANES-1:0]      i_wr_be;
  logic [ADDR_WIDTH-1:0] i_wr_addr;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  o_wr_err;

  modport master (
    output i_rd_req, i_rd_addr, i_rd_ready,
    output i_if_req, i_if_addr, i_if_ready,
    output i_wr_en, i_wr_be, i_wr_addr, i_wr_data,
    input  o_rd_valid, o_rd_data, o_rd_err,
    input  o_if_valid, o_if_data, o_if_err,
    input  o_wr_err
  );

  modport slave (
    input  i_rd_req, i_rd_addr, i_rd_ready,
    input  i_if_req, i_if_addr, i_if_ready,
    input  i_wr_en, i_wr_be, i_wr_addr, i_wr_data,
    output o_rd_valid, o_rd_data, o_rd_err,
    output o_if_valid, o_if_data, o_if_err,
    output o_wr_err
  );
endinterface

// File: rtl/ram_sync_2r1w.sv
// Byte-lane RAM with one byte-enabled write port and two registered, handshaked read ports
// (port 0 = load/store, port 1 = fetch), write-first forwarding and address checking.
module ram_sync_2r1w #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 32
) (
  input logic             clk,
  input logic             rst_n,
  input logic             clk_en,
  ram_sync_2r1w_if.slave  bus
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(LANES);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {EMPTY, FULL} port_state_e;

  function automatic logic is_bad(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] word;
    word = addr >> LSB;
    return ((addr & ADDR_WIDTH'(LANES - 1)) != '0) || (word >= ADDR_WIDTH'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_WIDTH-1:0] addr);
    return IDX_W'(addr >> LSB);
  endfunction

  logic [1:0]                  req, ready, bad_r;
  logic [1:0][IDX_W-1:0]       ridx;
  wire  [1:0]                  accept;
  wire  [1:0]                  out_valid, out_err, out_zero;
  wire  [1:0][DATA_WIDTH-1:0]  raw;

  assign req   = {bus.i_if_req,   bus.i_rd_req};
  assign ready = {bus.i_if_ready, bus.i_rd_ready};
  assign bad_r = {is_bad(bus.i_if_addr), is_bad(bus.i_rd_addr)};
  assign ridx  = {idx_of(bus.i_if_addr), idx_of(bus.i_rd_addr)};

  logic             wr_bad, wr_ok;
  logic [IDX_W-1:0] widx;
  assign wr_bad = is_bad(bus.i_wr_addr);
  assign wr_ok  = clk_en && bus.i_wr_en && !wr_bad;
  assign widx   = idx_of(bus.i_wr_addr);

  // One 8-bit bank per lane; each read port owns a registered read of every bank.
  for (genvar k = 0; k < LANES; k++) begin : g_bank
    logic [7:0]      mem [DEPTH];
    logic [1:0][7:0] q;
    logic            lane_we;
    logic [7:0]      lane_wd;

    assign lane_we = wr_ok && bus.i_wr_be[k];
    assign lane_wd = bus.i_wr_data[8*k +: 8];

    // NOTE: no reset on the array or its read registers, so it maps onto block RAM; contents survive rst_n.
    always_ff @(posedge clk) begin
      if (lane_we) mem[widx] <= lane_wd;
      for (int p = 0; p < 2; p++) begin
        if (accept[p]) q[p] <= (lane_we && widx == ridx[p]) ? lane_wd : mem[ridx[p]];
      end
    end

    assign raw[0][8*k +: 8] = q[0];
    assign raw[1][8*k +: 8] = q[1];
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    port_state_e state;
    logic        valid, err, zero;

    assign accept[p] = req[p] && clk_en && (state == EMPTY || ready[p]);

    // NOTE: non-blocking assignments keep every register sampling pre-edge values, whatever the order.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= EMPTY;
        valid <= 1'b0;
        err   <= 1'b0;
        zero  <= 1'b1;
      end else if (clk_en) begin
        if (accept[p]) begin
          state <= FULL;
          valid <= 1'b1;
          err   <= bad_r[p];
          zero  <= bad_r[p];
        end else if (state == FULL && ready[p]) begin
          state <= EMPTY;
          valid <= 1'b0;
        end
      end
    end

    assign out_valid[p] = valid;
    assign out_err[p]   = err;
    assign out_zero[p]  = zero;
  end

  // A zeroed response (reset or rejected address) masks whatever the bank register still holds.
  assign bus.o_rd_valid = out_valid[0];
  assign bus.o_rd_err   = out_err[0];
  assign bus.o_rd_data  = out_zero[0] ? '0 : raw[0];
  assign bus.o_if_valid = out_valid[1];
  assign bus.o_if_err   = out_err[1];
  assign bus.o_if_data  = out_zero[1] ? '0 : raw[1];

  logic wr_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      wr_err_q <= 1'b0;
    else if (clk_en) wr_err_q <= bus.i_wr_en && (bus.i_wr_be != '0) && wr_bad;
  end
  assign bus.o_wr_err = wr_err_q;
endmodule

// File: tb/tb_ram_sync_2r1w.sv
// Directed bench for ram_sync_2r1w: a word-level reference model checked every cycle,
// plus literal expectations taken from hand-worked scenarios.
module tb_ram_sync_2r1w;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic clk_en = 1'b0;
  always #5 clk = ~clk;

  ram_sync_2r1w_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  ram_sync_2r1w #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (whole words, spec rules) ----------------
  logic [31:0] m_mem [DEPTH];
  logic        m_rd_v, m_if_v, m_rd_e, m_if_e, m_wr_e;
  logic [31:0] m_rd_d, m_if_d;

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= DEPTH);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] read_word(input logic [31:0] a);
    logic [31:0] w;
    if (addr_bad(a)) return 32'h0;
    w = m_mem[a / 4];
    if (bus.i_wr_en && !addr_bad(bus.i_wr_addr) && bus.i_wr_addr / 4 == a / 4)
      w = merge(w, bus.i_wr_data, bus.i_wr_be);
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rd_v <= 1'b0; m_rd_e <= 1'b0; m_rd_d <= 32'h0;
      m_if_v <= 1'b0; m_if_e <= 1'b0; m_if_d <= 32'h0;
      m_wr_e <= 1'b0;
    end else if (clk_en) begin
      if (bus.i_rd_req && (!m_rd_v || bus.i_rd_ready)) begin
        m_rd_v <= 1'b1; m_rd_e <= addr_bad(bus.i_rd_addr); m_rd_d <= read_word(bus.i_rd_addr);
      end else if (m_rd_v && bus.i_rd_ready) m_rd_v <= 1'b0;
      if (bus.i_if_req && (!m_if_v || bus.i_if_ready)) begin
        m_if_v <= 1'b1; m_if_e <= addr_bad(bus.i_if_addr); m_if_d <= read_word(bus.i_if_addr);
      end else if (m_if_v && bus.i_if_ready) m_if_v <= 1'b0;
      m_wr_e <= bus.i_wr_en && bus.i_wr_be != 4'h0 && addr_bad(bus.i_wr_addr);
      if (bus.i_wr_en && !addr_bad(bus.i_wr_addr))
        m_mem[bus.i_wr_addr / 4] <= merge(m_mem[bus.i_wr_addr / 4], bus.i_wr_data, bus.i_wr_be);
    end
  end

  always @(negedge clk) begin
    check("rd_valid", 32'(bus.o_rd_valid), 32'(m_rd_v));
    check("rd_err",   32'(bus.o_rd_err),   32'(m_rd_e));
    check("rd_data",  bus.o_rd_data,       m_rd_d);
    check("if_valid", 32'(bus.o_if_valid), 32'(m_if_v));
    check("if_err",   32'(bus.o_if_err),   32'(m_if_e));
    check("if_data",  bus.o_if_data,       m_if_d);
    check("wr_err",   32'(bus.o_wr_err),   32'(m_wr_e));
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic en, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be);
    bus.i_wr_en   = en;
    bus.i_wr_addr = addr;
    bus.i_wr_data = data;
    bus.i_wr_be   = be;
  endtask

  initial begin
    bus.i_rd_req = 1'b0; bus.i_rd_addr = '0; bus.i_rd_ready = 1'b1;
    bus.i_if_req = 1'b0; bus.i_if_addr = '0; bus.i_if_ready = 1'b1;
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    clk_en = 1'b1;
    repeat (2) cyc();
    check("reset_rd_valid", 32'(bus.o_rd_valid), 32'h0);
    check("reset_if_valid", 32'(bus.o_if_valid), 32'h0);
    check("reset_rd_data",  bus.o_rd_data,       32'h0);
    check("reset_wr_err",   32'(bus.o_wr_err),   32'h0);
    rst_n = 1'b1;

    set_wr(1'b1, 32'h00, 32'h55AA_55AA, 4'hF); cyc();
    set_wr(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF); cyc();
    set_wr(1'b1, 32'h14, 32'h0123_4567, 4'hF);
    bus.i_rd_req = 1'b1; bus.i_rd_addr = 32'h10; cyc();
    check("full_write_valid", 32'(bus.o_rd_valid), 32'h1);
    check("full_write_data",  bus.o_rd_data,       32'hDEAD_BEEF);
    check("full_write_err",   32'(bus.o_rd_err),   32'h0);

    bus.i_rd_req = 1'b0;
    set_wr(1'b1, 32'h10, 32'h00AB_CD00, 4'h6); cyc();
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    bus.i_rd_req = 1'b1; cyc();
    check("partial_write", bus.o_rd_data, 32'hDEAB_CDEF);
    set_wr(1'b1, 32'h10, 32'h1122_3344, 4'h1); cyc();
    check("forward_write_first", bus.o_rd_data, 32'hDEAB_CD44);

    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    bus.i_rd_req = 1'b0; cyc();
    bus.i_rd_req = 1'b1; bus.i_rd_ready = 1'b0; cyc();
    check("stall_accept", bus.o_rd_data, 32'hDEAB_CD44);
    set_wr(1'b1, 32'h10, 32'h0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      cyc();
      set_wr(1'b0, 32'h0, 32'h0, 4'h0);
      check("stall_hold_data",  bus.o_rd_data,       32'hDEAB_CD44);
      check("stall_hold_valid", 32'(bus.o_rd_valid), 32'h1);
    end
    bus.i_rd_ready = 1'b1; bus.i_rd_addr = 32'h14; cyc();
    check("stall_release_next", bus.o_rd_data, 32'h0123_4567);
    bus.i_rd_req = 1'b0; cyc();
    check("drain_valid", 32'(bus.o_rd_valid), 32'h0);
    check("drain_data_held", bus.o_rd_data, 32'h0123_4567);

    bus.i_rd_req = 1'b1; bus.i_rd_addr = 32'h13; cyc();
    check("misaligned_err",  32'(bus.o_rd_err), 32'h1);
    check("misaligned_data", bus.o_rd_data,     32'h0);
    bus.i_rd_req = 1'b0;
    bus.i_if_req = 1'b1; bus.i_if_addr = 32'h1000; cyc();
    check("range_err",  32'(bus.o_if_err), 32'h1);
    check("range_data", bus.o_if_data,     32'h0);
    bus.i_if_req = 1'b0;
    set_wr(1'b1, 32'h1002, 32'hFFFF_FFFF, 4'hF); cyc();
    check("wr_err_pulse", 32'(bus.o_wr_err), 32'h1);
    set_wr(1'b0, 32'h0, 32'h0, 4'h0); cyc();
    check("wr_err_one_cycle", 32'(bus.o_wr_err), 32'h0);
    bus.i_rd_req = 1'b1; bus.i_rd_addr = 32'h00; cyc();
    check("bad_write_no_effect", bus.o_rd_data, 32'h55AA_55AA);
    bus.i_rd_req = 1'b0;
    set_wr(1'b1, 32'h1001, 32'hFFFF_FFFF, 4'h0); cyc();
    check("zero_be_no_err", 32'(bus.o_wr_err), 32'h0);
    set_wr(1'b1, 32'h10, 32'hCAFE_F00D, 4'hF); cyc();

    set_wr(1'b1, 32'h1002, 32'h0, 4'hF);
    bus.i_rd_req = 1'b1; bus.i_rd_addr = 32'h10;
    bus.i_if_req = 1'b1; bus.i_if_addr = 32'h10; cyc();
    check("dual_rd_data", bus.o_rd_data, 32'hCAFE_F00D);
    check("dual_if_data", bus.o_if_data, 32'hCAFE_F00D);
    check("dual_wr_err",  32'(bus.o_wr_err), 32'h1);
    clk_en = 1'b0;
    set_wr(1'b1, 32'h10, 32'h0, 4'hF);
    bus.i_rd_addr = 32'h00; bus.i_if_addr = 32'h00;
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("frozen_rd_data", bus.o_rd_data,       32'hCAFE_F00D);
      check("frozen_if_data", bus.o_if_data,       32'hCAFE_F00D);
      check("frozen_wr_err",  32'(bus.o_wr_err),   32'h1);
      check("frozen_valid",   32'(bus.o_if_valid), 32'h1);
    end
    clk_en = 1'b1;
    set_wr(1'b0, 32'h0, 32'h0, 4'h0); cyc();
    check("resume_rd_data", bus.o_rd_data,     32'h55AA_55AA);
    check("resume_if_data", bus.o_if_data,     32'h55AA_55AA);
    check("resume_wr_err",  32'(bus.o_wr_err), 32'h0);
    bus.i_rd_req = 1'b0; bus.i_if_req = 1'b0; cyc();

    bus.i_if_req = 1'b1; bus.i_if_addr = 32'h10; cyc();
    check("pre_reset_if_valid", 32'(bus.o_if_valid), 32'h1);
    check("pre_reset_if_data",  bus.o_if_data,       32'hCAFE_F00D);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(bus.o_if_valid), 32'h0);
    check("async_reset_data",  bus.o_if_data,       32'h0);
    bus.i_if_req = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    bus.i_rd_req = 1'b1; bus.i_rd_addr = 32'h10; cyc();
    check("mem_kept_over_reset", bus.o_rd_data, 32'hCAFE_F00D);
    bus.i_rd_req = 1'b0; cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
